baud_cfg_sequencer: RTL and testbench



---
 rtl/uart_cfg_pkg.sv | 48 ++++
 rtl/baud_cfg_sequencer.sv | 149 ++++++++++++++
 tb/tb_baud_cfg_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cfg_pkg.sv
// Shared constants, state encodings and the configuration validity check
// for the baudrate-generator configuration sequencer.
package uart_cfg_pkg;

    localparam int          BITS_PER_FRAME = 11;
    localparam logic [12:0] MIN_ACQ_PERIOD = 13'd4;
    localparam logic [12:0] DEF_ACQ_PERIOD = 13'd54;
    localparam logic [7:0]  DEF_POS_COMP   = 8'h71;
    localparam logic [7:0]  DEF_NEG_COMP   = 8'h70;
    localparam logic [7:0]  DEF_BYTE_COMP  = 8'h65;

    // Nibble layout shared by all three compensation bytes.
    localparam int NIB_HI_MSB = 7;
    localparam int NIB_HI_LSB = 4;
    localparam int NIB_LO_MSB = 3;
    localparam int NIB_LO_LSB = 0;

    typedef logic [2:0] state_t;

    localparam state_t ST_OFF     = 3'd0;
    localparam state_t ST_RUN     = 3'd1;
    localparam state_t ST_DRAIN   = 3'd2;
    localparam state_t ST_QUIESCE = 3'd3;
    localparam state_t ST_APPLY   = 3'd4;

    function automatic logic [4:0] nibble_sum(input logic [7:0] b);
        return {1'b0, b[NIB_HI_MSB:NIB_HI_LSB]} + {1'b0, b[NIB_LO_MSB:NIB_LO_LSB]};
    endfunction

    function automatic logic cfg_valid(
        input logic [12:0] acq,
        input logic [7:0]  pos,
        input logic [7:0]  neg,
        input logic [7:0]  byte_comp,
        input logic [12:0] min_acq,
        input logic [4:0]  frame_bits
    );
        logic [4:0] pos_sum;
        logic [4:0] neg_sum;
        pos_sum = nibble_sum(pos);
        neg_sum = nibble_sum(neg);
        return (acq >= min_acq)
            && (pos_sum >= 5'd1) && (pos_sum <= 5'd15)
            && (neg_sum >= 5'd1) && (neg_sum <= 5'd15)
            && (nibble_sum(byte_comp) == frame_bits);
    endfunction

endpackage

// File: rtl/baud_cfg_sequencer.sv
// Validates a new baudrate configuration set, drains the link, gates the
// generator off, applies the set atomically and restarts the generator.
module baud_cfg_sequencer #(
    parameter int          BITS_PER_FRAME = uart_cfg_pkg::BITS_PER_FRAME,
    parameter logic [12:0] MIN_ACQ_PERIOD = uart_cfg_pkg::MIN_ACQ_PERIOD,
    parameter int          SETTLE_CYCLES  = 4,
    parameter logic [15:0] DRAIN_TIMEOUT  = 16'd50000,
    parameter logic [12:0] DEF_ACQ_PERIOD = uart_cfg_pkg::DEF_ACQ_PERIOD,
    parameter logic [7:0]  DEF_POS_COMP   = uart_cfg_pkg::DEF_POS_COMP,
    parameter logic [7:0]  DEF_NEG_COMP   = uart_cfg_pkg::DEF_NEG_COMP,
    parameter logic [7:0]  DEF_BYTE_COMP  = uart_cfg_pkg::DEF_BYTE_COMP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        CfgWr_i,
    input  logic [12:0] CfgAcqPeriod_i,
    input  logic [7:0]  CfgPosComp_i,
    input  logic [7:0]  CfgNegComp_i,
    input  logic [7:0]  CfgByteComp_i,
    input  logic        Enable_i,
    input  logic        TxBusy_i,
    input  logic        RxBusy_i,
    output logic [12:0] AcqPeriod_o,
    output logic [7:0]  PosCompensation_o,
    output logic [7:0]  NegCompensation_o,
    output logic [7:0]  ByteCompensation_o,
    output logic        BaudEn_o,
    output logic        CfgBusy_o,
    output logic        CfgDone_o,
    output logic        CfgErr_o,
    output logic        CfgForced_o
);
    import uart_cfg_pkg::*;

    state_t      state;
    state_t      state_nx;
    logic [15:0] drain_cnt;
    logic [15:0] drain_nx;
    logic [3:0]  settle_cnt;
    logic [3:0]  settle_nx;
    logic        forced_set;

    logic [12:0] sh_acq;
    logic [7:0]  sh_pos;
    logic [7:0]  sh_neg;
    logic [7:0]  sh_byte;

    logic cfg_ok;
    logic busy;
    logic wr_ok;

    assign cfg_ok = cfg_valid(CfgAcqPeriod_i, CfgPosComp_i, CfgNegComp_i, CfgByteComp_i,
                              MIN_ACQ_PERIOD, 5'(BITS_PER_FRAME));
    assign busy   = (state == ST_DRAIN) || (state == ST_QUIESCE) || (state == ST_APPLY);
    // A request is only taken when nothing is pending and the set checks out.
    assign wr_ok  = CfgWr_i && !busy && cfg_ok;

    always_comb begin
        state_nx   = state;
        drain_nx   = drain_cnt;
        settle_nx  = settle_cnt;
        forced_set = 1'b0;
        case (state)
            ST_OFF: begin
                if (CfgWr_i) begin
                    if (wr_ok) state_nx = ST_APPLY;
                end else if (Enable_i) begin
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                if (CfgWr_i) begin
                    if (wr_ok) begin
                        state_nx = ST_DRAIN;
                        drain_nx = 16'd0;
                    end
                end else if (!Enable_i) begin
                    state_nx = ST_OFF;
                end
            end
            ST_DRAIN: begin
                if (!TxBusy_i && !RxBusy_i) begin
                    state_nx  = ST_QUIESCE;
                    settle_nx = 4'd0;
                end else if (drain_cnt == DRAIN_TIMEOUT - 16'd1) begin
                    state_nx   = ST_QUIESCE;
                    settle_nx  = 4'd0;
                    forced_set = 1'b1;
                end else begin
                    drain_nx = drain_cnt + 16'd1;
                end
            end
            ST_QUIESCE: begin
                if (settle_cnt == 4'(SETTLE_CYCLES - 1)) state_nx = ST_APPLY;
                else settle_nx = settle_cnt + 4'd1;
            end
            ST_APPLY: begin
                state_nx = Enable_i ? ST_RUN : ST_OFF;
            end
            default: state_nx = ST_OFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= ST_OFF;
            drain_cnt          <= 16'd0;
            settle_cnt         <= 4'd0;
            sh_acq             <= DEF_ACQ_PERIOD;
            sh_pos             <= DEF_POS_COMP;
            sh_neg             <= DEF_NEG_COMP;
            sh_byte            <= DEF_BYTE_COMP;
            AcqPeriod_o        <= DEF_ACQ_PERIOD;
            PosCompensation_o  <= DEF_POS_COMP;
            NegCompensation_o  <= DEF_NEG_COMP;
            ByteCompensation_o <= DEF_BYTE_COMP;
            BaudEn_o           <= 1'b0;
            CfgBusy_o          <= 1'b0;
            CfgDone_o          <= 1'b0;
            CfgErr_o           <= 1'b0;
            CfgForced_o        <= 1'b0;
        end else begin
            state      <= state_nx;
            drain_cnt  <= drain_nx;
            settle_cnt <= settle_nx;
            if (wr_ok) begin
                sh_acq  <= CfgAcqPeriod_i;
                sh_pos  <= CfgPosComp_i;
                sh_neg  <= CfgNegComp_i;
                sh_byte <= CfgByteComp_i;
            end
            // The generator only ever sees a complete set, swapped in one edge.
            if (state == ST_APPLY) begin
                AcqPeriod_o        <= sh_acq;
                PosCompensation_o  <= sh_pos;
                NegCompensation_o  <= sh_neg;
                ByteCompensation_o <= sh_byte;
            end
            BaudEn_o  <= (state_nx == ST_RUN) || (state_nx == ST_DRAIN);
            CfgBusy_o <= (state_nx == ST_DRAIN) || (state_nx == ST_QUIESCE)
                      || (state_nx == ST_APPLY);
            CfgDone_o <= (state == ST_APPLY);
            CfgErr_o  <= CfgWr_i && !wr_ok;
            if (wr_ok) CfgForced_o <= 1'b0;
            else if (forced_set) CfgForced_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_baud_cfg_sequencer.sv
// Self-checking bench for baud_cfg_sequencer: scenario tasks plus a scoreboard
// that checks every applied set against the queue of accepted requests.
module tb_baud_cfg_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_wr;
    logic [12:0] cfg_acq;
    logic [7:0]  cfg_pos;
    logic [7:0]  cfg_neg;
    logic [7:0]  cfg_bytec;
    logic        enable;
    logic        tx_busy;
    logic        rx_busy;

    logic [12:0] acq;
    logic [7:0]  pos, neg, bytec;
    logic        baud_en, busy, done, err, forced;

    logic [12:0] t_acq;
    logic [7:0]  t_pos, t_neg, t_bytec;
    logic        t_baud_en, t_busy, t_done, t_err, t_forced;

    int tests = 0;
    int fails = 0;

    logic [36:0] exp_q[$];
    logic [36:0] cur_set;

    localparam logic [36:0] DEF_SET = {13'd54, 8'h71, 8'h70, 8'h65};

    always #5 clk = ~clk;

    baud_cfg_sequencer dut (
        .clk(clk), .rst(rst), .CfgWr_i(cfg_wr), .CfgAcqPeriod_i(cfg_acq),
        .CfgPosComp_i(cfg_pos), .CfgNegComp_i(cfg_neg), .CfgByteComp_i(cfg_bytec),
        .Enable_i(enable), .TxBusy_i(tx_busy), .RxBusy_i(rx_busy),
        .AcqPeriod_o(acq), .PosCompensation_o(pos), .NegCompensation_o(neg),
        .ByteCompensation_o(bytec), .BaudEn_o(baud_en), .CfgBusy_o(busy),
        .CfgDone_o(done), .CfgErr_o(err), .CfgForced_o(forced)
    );

    baud_cfg_sequencer #(.DRAIN_TIMEOUT(16'd16)) dut_t (
        .clk(clk), .rst(rst), .CfgWr_i(cfg_wr), .CfgAcqPeriod_i(cfg_acq),
        .CfgPosComp_i(cfg_pos), .CfgNegComp_i(cfg_neg), .CfgByteComp_i(cfg_bytec),
        .Enable_i(enable), .TxBusy_i(tx_busy), .RxBusy_i(rx_busy),
        .AcqPeriod_o(t_acq), .PosCompensation_o(t_pos), .NegCompensation_o(t_neg),
        .ByteCompensation_o(t_bytec), .BaudEn_o(t_baud_en), .CfgBusy_o(t_busy),
        .CfgDone_o(t_done), .CfgErr_o(t_err), .CfgForced_o(t_forced)
    );

    // Scoreboard: every done pulse of the main instance must match the oldest accepted set.
    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL done_pulse: CfgDone_o=1 with no set pending, outputs=%h", {acq, pos, neg, bytec});
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                if ({acq, pos, neg, bytec} !== e) begin
                    fails++;
                    $display("FAIL applied_set: got %h expected %h", {acq, pos, neg, bytec}, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [12:0] a, input logic [7:0] p, input logic [7:0] n,
                        input logic [7:0] b);
        cfg_acq   = a;
        cfg_pos   = p;
        cfg_neg   = n;
        cfg_bytec = b;
        cfg_wr    = 1'b1;
        tick();
        cfg_wr    = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        tests++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL wait_done: CfgDone_o=%b after %0d cycles, required 1", done, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cfg_wr = 1'b0; enable = 1'b0; tx_busy = 1'b0; rx_busy = 1'b0;
        cfg_acq = '0; cfg_pos = '0; cfg_neg = '0; cfg_bytec = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
        tests++;
        if ({acq, pos, neg, bytec} !== DEF_SET) begin
            fails++;
            $display("FAIL reset_set: got %h expected %h", {acq, pos, neg, bytec}, DEF_SET);
        end
        tests++;
        if ({baud_en, busy, done, err, forced} !== 5'b0) begin
            fails++;
            $display("FAIL reset_flags: got %b expected 00000", {baud_en, busy, done, err, forced});
        end
        enable = 1'b1;
        tick();
        tests++;
        if (baud_en !== 1'b1 || {acq, bytec} !== {13'd54, 8'h65}) begin
            fails++;
            $display("FAIL enable_run: baud_en=%b acq=%0d byte=%h, required 1/54/65", baud_en, acq, bytec);
        end
        cur_set = DEF_SET;
    endtask

    task automatic test_apply_latency();
        logic bad = 1'b0;
        send(13'd27, 8'h71, 8'h70, 8'h56);
        exp_q.push_back({13'd27, 8'h71, 8'h70, 8'h56});
        tests++;
        if (baud_en !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL drain_entry: baud_en=%b busy=%b, required 1/1", baud_en, busy);
        end
        for (int i = 2; i <= 5; i++) begin
            tick();
            if (baud_en !== 1'b0 || {acq, pos, neg, bytec} !== cur_set) bad = 1'b1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL quiesce_gate: baud_en=%b set=%h during T+2..T+5, required 0/%h", baud_en, {acq, pos, neg, bytec}, cur_set);
        end
        tick();
        tests++;
        if (done !== 1'b0 || baud_en !== 1'b0) begin
            fails++;
            $display("FAIL apply_cycle: done=%b baud_en=%b, required 0/0", done, baud_en);
        end
        tick();
        tests++;
        if (done !== 1'b1 || acq !== 13'd27 || baud_en !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL t_plus_7: done=%b acq=%0d baud_en=%b busy=%b, required 1/27/1/0", done, acq, baud_en, busy);
        end
        cur_set = {13'd27, 8'h71, 8'h70, 8'h56};
        tick();
    endtask

    task automatic test_invalid();
        logic [36:0] bad_sets[6];
        bad_sets[0] = {13'd40, 8'h71, 8'h70, 8'h55};
        bad_sets[1] = {13'd3,  8'h71, 8'h70, 8'h56};
        bad_sets[2] = {13'd40, 8'h00, 8'h70, 8'h56};
        bad_sets[3] = {13'd40, 8'hF1, 8'h70, 8'h56};
        bad_sets[4] = {13'd40, 8'h71, 8'h88, 8'h56};
        bad_sets[5] = {13'd40, 8'h71, 8'h70, 8'h66};
        for (int i = 0; i < 6; i++) begin
            send(bad_sets[i][36:24], bad_sets[i][23:16], bad_sets[i][15:8], bad_sets[i][7:0]);
            tests++;
            if (err !== 1'b1 || busy !== 1'b0 || baud_en !== 1'b1 || {acq, pos, neg, bytec} !== cur_set) begin
                fails++;
                $display("FAIL invalid_%0d: err=%b busy=%b baud_en=%b set=%h, required 1/0/1/%h",
                         i, err, busy, baud_en, {acq, pos, neg, bytec}, cur_set);
            end
            tick();
            tests++;
            if (err !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL invalid_pulse_%0d: err=%b busy=%b, required 0/0", i, err, busy);
            end
        end
    endtask

    task automatic test_drain_busy();
        logic bad = 1'b0;
        tx_busy = 1'b1;
        send(13'd100, 8'h32, 8'h23, 8'hB0);
        exp_q.push_back({13'd100, 8'h32, 8'h23, 8'hB0});
        for (int i = 0; i < 100; i++) begin
            if (baud_en !== 1'b1 || busy !== 1'b1) bad = 1'b1;
            tick();
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL drain_hold: baud_en=%b busy=%b while TxBusy high, required 1/1", baud_en, busy);
        end
        tx_busy = 1'b0;
        tick();
        tests++;
        if (baud_en !== 1'b0 || forced !== 1'b0) begin
            fails++;
            $display("FAIL drain_exit: baud_en=%b forced=%b, required 0/0", baud_en, forced);
        end
        wait_done();
        tests++;
        if (forced !== 1'b0) begin
            fails++;
            $display("FAIL drain_forced: forced=%b, required 0", forced);
        end
        cur_set = {13'd100, 8'h32, 8'h23, 8'hB0};
        tick();
    endtask

    task automatic test_enable_drop();
        send(13'd200, 8'h44, 8'h33, 8'h83);
        exp_q.push_back({13'd200, 8'h44, 8'h33, 8'h83});
        tick();
        enable = 1'b0;
        wait_done();
        tests++;
        if (baud_en !== 1'b0 || busy !== 1'b0 || acq !== 13'd200) begin
            fails++;
            $display("FAIL enable_drop: baud_en=%b busy=%b acq=%0d, required 0/0/200", baud_en, busy, acq);
        end
        tick();
        send(13'd4, 8'hF0, 8'h01, 8'h29);
        exp_q.push_back({13'd4, 8'hF0, 8'h01, 8'h29});
        tests++;
        if (busy !== 1'b1 || baud_en !== 1'b0) begin
            fails++;
            $display("FAIL off_apply: busy=%b baud_en=%b, required 1/0", busy, baud_en);
        end
        tick();
        tests++;
        if (done !== 1'b1 || acq !== 13'd4 || baud_en !== 1'b0) begin
            fails++;
            $display("FAIL off_done: done=%b acq=%0d baud_en=%b, required 1/4/0", done, acq, baud_en);
        end
        enable = 1'b1;
        tick();
        tick();
        tests++;
        if (baud_en !== 1'b1) begin
            fails++;
            $display("FAIL re_enable: baud_en=%b, required 1", baud_en);
        end
    endtask

    task automatic test_timeout_overrun();
        logic bad = 1'b0;
        int n = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick(); tick();
        tx_busy = 1'b1;
        send(13'd77, 8'h52, 8'h34, 8'h74);
        exp_q.push_back({13'd77, 8'h52, 8'h34, 8'h74});
        for (int i = 0; i < 16; i++) begin
            if (t_forced !== 1'b0 || t_baud_en !== 1'b1) bad = 1'b1;
            if (i < 15) tick();
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL timeout_drain: forced=%b baud_en=%b over 16 drain cycles, required 0/1", t_forced, t_baud_en);
        end
        tick();
        tests++;
        if (t_forced !== 1'b1 || t_baud_en !== 1'b0) begin
            fails++;
            $display("FAIL timeout_forced: forced=%b baud_en=%b, required 1/0", t_forced, t_baud_en);
        end
        send(13'd99, 8'h61, 8'h16, 8'hA1);
        tests++;
        if (t_err !== 1'b1 || err !== 1'b1) begin
            fails++;
            $display("FAIL overrun_err: t_err=%b err=%b, required 1/1", t_err, err);
        end
        while (t_done !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        tests++;
        if (t_done !== 1'b1 || {t_acq, t_pos, t_neg, t_bytec} !== {13'd77, 8'h52, 8'h34, 8'h74} || t_forced !== 1'b1) begin
            fails++;
            $display("FAIL overrun_apply: done=%b set=%h forced=%b, required 1/%h/1",
                     t_done, {t_acq, t_pos, t_neg, t_bytec}, t_forced, {13'd77, 8'h52, 8'h34, 8'h74});
        end
        tx_busy = 1'b0;
        wait_done();
        tick();
        send(13'd60, 8'h71, 8'h70, 8'h65);
        exp_q.push_back({13'd60, 8'h71, 8'h70, 8'h65});
        tests++;
        if (t_forced !== 1'b0) begin
            fails++;
            $display("FAIL forced_clear: forced=%b, required 0", t_forced);
        end
        wait_done();
        tick();
    endtask

    task automatic test_reset_mid_sequence();
        send(13'd500, 8'h71, 8'h70, 8'h56);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if ({acq, pos, neg, bytec} !== DEF_SET || {baud_en, busy, done, err, forced} !== 5'b0) begin
            fails++;
            $display("FAIL reset_mid: set=%h flags=%b, required %h/00000",
                     {acq, pos, neg, bytec}, {baud_en, busy, done, err, forced}, DEF_SET);
        end
        for (int i = 0; i < 12; i++) tick();
        tests++;
        if (exp_q.size() != 0 || {acq, pos, neg, bytec} !== DEF_SET) begin
            fails++;
            $display("FAIL reset_discard: pending=%0d set=%h, required 0/%h", exp_q.size(), {acq, pos, neg, bytec}, DEF_SET);
        end
    endtask

    initial begin
        test_reset();
        test_apply_latency();
        test_invalid();
        test_drain_busy();
        test_enable_drop();
        test_timeout_overrun();
        test_reset_mid_sequence();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
